// File: rtl/afns_link_ctrl_6_2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | afns_link_ctrl_6_2 : 6+2 local-AFNS CAC TSV link sequencer / f_flag owner   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module afns_link_ctrl_6_2 #(
    parameter int TSV_NUM    = 8,
    parameter int DW         = 5,
    parameter int DATA_MAX   = 20,
    parameter int MAX_FAULT  = 2,
    parameter int SETTLE_CYC = 3
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [TSV_NUM-1:0] fault_in_i,
    input  logic               fault_upd_i,
    input  logic               src_valid_i,
    input  logic [DW-1:0]      src_data_i,
    output logic               src_ready_o,
    output logic [DW-1:0]      enc_data_o,
    output logic               enc_load_o,
    output logic [TSV_NUM-1:0] f_flag_o,
    output logic [3:0]         fault_cnt_o,
    output logic               link_busy_o,
    output logic               upd_ack_o,
    output logic               range_err_o,
    output logic               link_fail_o
);

    localparam logic [DW-1:0] DATA_MAX_V  = DW'(DATA_MAX);
    localparam logic [3:0]    MAX_FAULT_V = 4'(MAX_FAULT);
    localparam logic [3:0]    SETTLE_INIT = 4'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        DRAIN  = 3'd1,
        APPLY  = 3'd2,
        SETTLE = 3'd3,
        FAIL   = 3'd4
    } state_t;

    state_t             state_q;
    logic [DW-1:0]      enc_data_q;
    logic               enc_load_q;
    logic [TSV_NUM-1:0] f_flag_q;
    logic [3:0]         fault_cnt_q;
    logic               upd_ack_q;
    logic               range_err_q;
    logic               link_fail_q;
    logic [TSV_NUM-1:0] pend_q;
    logic               pend_dirty_q;
    logic [3:0]         settle_q;
    logic [3:0]         pend_pop;

    always_comb begin
        pend_pop = '0;
        for (int i = 0; i < TSV_NUM; i++) begin
            pend_pop = pend_pop + {3'b000, pend_q[i]};
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= RUN;
            enc_data_q   <= '0;
            enc_load_q   <= 1'b0;
            f_flag_q     <= '0;
            fault_cnt_q  <= '0;
            upd_ack_q    <= 1'b0;
            range_err_q  <= 1'b0;
            link_fail_q  <= 1'b0;
            pend_q       <= '0;
            pend_dirty_q <= 1'b0;
            settle_q     <= '0;
        end else begin
            enc_load_q  <= 1'b0;
            range_err_q <= 1'b0;
            upd_ack_q   <= 1'b0;

            // Updates arriving mid-sequence merge into the pre-commit pend.
            if (fault_upd_i && (state_q == DRAIN || state_q == APPLY || state_q == SETTLE)) begin
                pend_q       <= pend_q | fault_in_i;
                pend_dirty_q <= 1'b1;
            end

            case (state_q)
                RUN: begin
                    if (src_valid_i) begin
                        if (src_data_i <= DATA_MAX_V) begin
                            enc_data_q <= src_data_i;
                            enc_load_q <= 1'b1;
                        end else begin
                            range_err_q <= 1'b1;
                        end
                    end
                    if (fault_upd_i) begin
                        pend_q  <= f_flag_q | fault_in_i;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_q <= APPLY;
                end
                APPLY: begin
                    if (pend_pop > MAX_FAULT_V) begin
                        link_fail_q <= 1'b1;
                        state_q     <= FAIL;
                    end else begin
                        f_flag_q    <= pend_q;
                        fault_cnt_q <= pend_pop;
                        settle_q    <= SETTLE_INIT;
                        state_q     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == 4'd0) begin
                        // A strobe on the expiry edge also forces another pass.
                        if (pend_dirty_q || fault_upd_i) begin
                            pend_dirty_q <= 1'b0;
                            state_q      <= DRAIN;
                        end else begin
                            upd_ack_q <= 1'b1;
                            state_q   <= RUN;
                        end
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                FAIL: begin
                    state_q <= FAIL;
                end
                default: begin
                    state_q <= FAIL;
                end
            endcase
        end
    end

    assign src_ready_o = (state_q == RUN);
    assign link_busy_o = (state_q != RUN);
    assign enc_data_o  = enc_data_q;
    assign enc_load_o  = enc_load_q;
    assign f_flag_o    = f_flag_q;
    assign fault_cnt_o = fault_cnt_q;
    assign upd_ack_o   = upd_ack_q;
    assign range_err_o = range_err_q;
    assign link_fail_o = link_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_afns_link_ctrl_6_2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_afns_link_ctrl_6_2 : scoreboard bench for the AFNS 6+2 link controller   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_afns_link_ctrl_6_2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] fault_in;
    logic       fault_upd;
    logic       src_valid;
    logic [4:0] src_data;
    logic       src_ready;
    logic [4:0] enc_data;
    logic       enc_load;
    logic [7:0] f_flag;
    logic [3:0] fault_cnt;
    logic       link_busy;
    logic       upd_ack;
    logic       range_err;
    logic       link_fail;

    int checks = 0;
    int errors = 0;

    // Expected output events: kind 0 = enc_load, 1 = range_err, 2 = upd_ack
    typedef struct {
        int         kind;
        logic [4:0] data;
        logic [7:0] ff;
    } ev_t;
    ev_t exp_q[$];

    afns_link_ctrl_6_2 dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .fault_in_i  (fault_in),
        .fault_upd_i (fault_upd),
        .src_valid_i (src_valid),
        .src_data_i  (src_data),
        .src_ready_o (src_ready),
        .enc_data_o  (enc_data),
        .enc_load_o  (enc_load),
        .f_flag_o    (f_flag),
        .fault_cnt_o (fault_cnt),
        .link_busy_o (link_busy),
        .upd_ack_o   (upd_ack),
        .range_err_o (range_err),
        .link_fail_o (link_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [4:0] data, input logic [7:0] ff);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.ff   = ff;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk({name, "_unexpected"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, kind, e.kind);
            if (kind == 0) begin
                chk("load_data", enc_data, e.data);
                chk("load_fflag", f_flag, e.ff);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (enc_load)  pop_cmp(0, "enc_load");
            if (range_err) pop_cmp(1, "range_err");
            if (upd_ack)   pop_cmp(2, "upd_ack");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; fault_in = '0; fault_upd = 1'b0; src_valid = 1'b0; src_data = '0;
        #2;
        chk("rst_enc_load", enc_load, 0);
        chk("rst_enc_data", enc_data, 0);
        chk("rst_f_flag", f_flag, 0);
        chk("rst_fault_cnt", fault_cnt, 0);
        chk("rst_link_fail", link_fail, 0);
        chk("rst_src_ready", src_ready, 1);
        chk("rst_link_busy", link_busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Stream 0..20 back to back
        for (int i = 0; i <= 20; i++) begin
            src_valid = 1'b1;
            src_data  = 5'(i);
            chk("stream_ready", src_ready, 1);
            push(0, 5'(i), 8'h00);
            cyc();
        end
        src_valid = 1'b0;
        cyc();

        // Out-of-range word is consumed but never loaded
        src_valid = 1'b1; src_data = 5'd21;
        push(1, 5'd0, 8'h00);
        cyc();
        src_valid = 1'b0;
        cyc();
        chk("range_enc_data_held", enc_data, 20);

        // Word 13 on the same edge as a fault update: loads under old f_flag
        src_valid = 1'b1; src_data = 5'd13; fault_upd = 1'b1; fault_in = 8'h04;
        push(0, 5'd13, 8'h00);
        push(2, 5'd0, 8'h00);
        cyc();
        src_valid = 1'b0; fault_upd = 1'b0; fault_in = '0;
        k = 0;
        while (!src_ready && k < 20) begin
            if (k == 1) chk("apply_fflag_old", f_flag, 8'h00);
            if (k == 2) chk("settle_fflag_new", f_flag, 8'h04);
            if (k == 2) chk("settle_busy", link_busy, 1);
            k++;
            cyc();
        end
        chk("stall_len", k, 5);
        chk("upd_ack_first_run", upd_ack, 1);
        chk("f_flag_04", f_flag, 8'h04);
        chk("fault_cnt_1", fault_cnt, 1);

        // Asynchronous reset in the middle of SETTLE
        fault_upd = 1'b1; fault_in = 8'h01;
        cyc();
        fault_upd = 1'b0; fault_in = '0;
        cyc(); cyc(); cyc();
        chk("pre_reset_fflag", f_flag, 8'h05);
        chk("pre_reset_busy", link_busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_fflag", f_flag, 0);
        chk("async_rst_cnt", fault_cnt, 0);
        chk("async_rst_enc_data", enc_data, 0);
        chk("async_rst_ready", src_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc();
        chk("post_rst_busy", link_busy, 0);
        chk("post_rst_ack", upd_ack, 0);

        // Second update during SETTLE forces another pass; one upd_ack only
        fault_upd = 1'b1; fault_in = 8'h01;
        push(2, 5'd0, 8'h00);
        cyc();
        fault_upd = 1'b0; fault_in = '0;
        cyc(); cyc(); cyc();
        fault_upd = 1'b1; fault_in = 8'h40;
        cyc();
        fault_upd = 1'b0; fault_in = '0;
        k = 0;
        while (!src_ready && k < 30) begin
            k++;
            cyc();
        end
        chk("double_stall_len", k, 6);
        chk("double_fflag", f_flag, 8'h41);
        chk("double_cnt", fault_cnt, 2);
        cyc(); cyc();

        // Unrepairable map: 0x41 | 0x81 = 0xC1 has three faults
        fault_upd = 1'b1; fault_in = 8'h81;
        cyc();
        fault_upd = 1'b0; fault_in = '0;
        cyc(); cyc();
        chk("fail_link_fail", link_fail, 1);
        chk("fail_ready", src_ready, 0);
        chk("fail_fflag_held", f_flag, 8'h41);
        chk("fail_cnt_held", fault_cnt, 2);
        fault_upd = 1'b1; fault_in = 8'hFF; src_valid = 1'b1; src_data = 5'd7;
        cyc();
        fault_upd = 1'b0; fault_in = '0;
        cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
        src_valid = 1'b0;
        cyc();
        chk("fail_ignore_fflag", f_flag, 8'h41);
        chk("fail_sticky", link_fail, 1);
        chk("fail_ready_low", src_ready, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/afns_link_ctrl_6_2.md
Name: afns_link_ctrl_6_2

Overview:
- Sequences the 6+2 local-AFNS CAC TSV link: accepts source words, issues one coder load per word, and owns the f_flag vector driven to both the sender and receiver FNSadders_6_2 instances.
- On a fault-map update it:
  - stalls the source,
  - drains the in-flight word,
  - checks repairability,
  - applies the new map,
  - waits for the FNS adder outputs to settle,
  - then resumes traffic.
- Sits between the data source, the fault-test logic and the coder_6_2/dec_6_2 pair.

Parameters:
- TSV_NUM, 8, number of TSVs (x+y); width of the fault vectors.
- DW, 5, data word width (BLEN_06).
- DATA_MAX, 20, largest legal code input value.
- MAX_FAULT, 2, maximum repairable faulty TSVs (redundant count).
- SETTLE_CYC, 3, cycles f_flag is held stable before traffic resumes; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- fault_in  in  TSV_NUM  new fault map; bit0 is the first TSV.
- fault_upd  in  1  one-cycle strobe; fault_in is valid when high.
- src_valid  in  1  source word valid.
- src_data  in  DW  source word.
- src_ready  out  1  controller accepts a word.
- enc_data  out  DW  registered word to coder_6_2 datain.
- enc_load  out  1  one-cycle coder capture strobe.
- f_flag  out  TSV_NUM  applied fault map to both adder instances.
- fault_cnt  out  4  popcount of f_flag.
- link_busy  out  1  high in every state except RUN.
- upd_ack  out  1  one-cycle pulse when a fault-map update completes.
- range_err  out  1  one-cycle pulse when a word > DATA_MAX is rejected.
- link_fail  out  1  sticky; unrepairable fault map.

Behaviour:
- Reset (asynchronous):
  - state=RUN;
  - enc_data, enc_load, f_flag, fault_cnt, upd_ack and range_err are all 0;
  - link_fail=0;
  - the pending map pend=0 and pend_dirty=0.
- Moore outputs: src_ready = (state==RUN); link_busy = (state!=RUN).
- FSM states: RUN, DRAIN, APPLY, SETTLE, FAIL.
- RUN:
  - Accept a beat when src_valid && src_ready at the edge.
  - If src_data <= DATA_MAX: enc_data <= src_data, and enc_load is high for exactly the next cycle.
  - Otherwise enc_data is unchanged, enc_load stays 0 and range_err pulses the next cycle. The beat is still consumed.
  - fault_upd high: pend <= f_flag | fault_in; go to DRAIN.
  - A handshake in the same cycle as fault_upd still completes and loads normally.
- DRAIN (1 cycle): lets the enc_load from the last accepted beat issue under the old f_flag; then go to APPLY.
- APPLY (1 cycle): n = popcount(pend).
  - If n > MAX_FAULT: go to FAIL; f_flag is unchanged; link_fail <= 1.
  - Otherwise f_flag <= pend and fault_cnt <= n at the end of the cycle; load the settle counter with SETTLE_CYC-1; go to SETTLE.
- SETTLE: counts down to 0 (SETTLE_CYC cycles total).
  - At expiry, if pend_dirty: clear it and go to DRAIN.
  - Otherwise go to RUN, with upd_ack high for the first RUN cycle.
- fault_upd while in DRAIN, APPLY or SETTLE: pend <= pend | fault_in and pend_dirty <= 1.
  - If this arrives in APPLY on the same edge that commits f_flag, the OR uses the pre-commit pend; no bit is lost.
- Faults are sticky: f_flag bits only set, never clear, except on reset.
- FAIL: absorbing until reset. src_ready=0, enc_load=0, fault_upd ignored, f_flag holds its last repairable value.
- Stall length per clean update: src_ready is low for 2+SETTLE_CYC cycles after the fault_upd edge.
- Reset mid-operation (any state) returns to the reset values immediately; a pending update is discarded.
- fault_cnt is a 4-bit popcount of an 8-bit vector, with no overflow.

Test Plan:
- Reset, then stream src_data 0..20 with src_valid=1 → one enc_load per word, enc_data equal to the inputs in order, f_flag=0, no stalls.
- In RUN, fault_upd with fault_in=8'b00000100 → src_ready low for 5 cycles; f_flag=8'h04 and fault_cnt=1 from the end of APPLY; upd_ack on the 6th cycle.
- Word 13 accepted on the same edge as fault_upd → enc_load with enc_data=13 in DRAIN, while f_flag is still the old value.
- f_flag=8'h04, then update 8'h81 → pend=8'h85, n=3 → link_fail=1, src_ready=0 permanently, f_flag stays 8'h04; a further fault_upd is ignored.
- Update 8'h01, then 8'h40 during SETTLE → second DRAIN/APPLY pass; final f_flag=8'h41, fault_cnt=2; a single upd_ack after the second pass.
- src_data=21 → range_err pulse, no enc_load. Then assert reset during SETTLE → all outputs return to 0 asynchronously; state RUN after release.
